// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer: per-sample PID update sequenced over one shared
// multiplier, with integrator/previous-error state and saturated output.
module pid_loop_sequencer #(
    parameter int INT_LIM   = 32767,
    parameter int FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_tick,
    input  logic [15:0] setpoint,
    input  logic [15:0] focus_signal,
    input  logic [15:0] kp,
    input  logic [15:0] ki,
    input  logic [15:0] kd,
    input  logic [15:0] threshold,
    input  logic        mute,
    output logic [15:0] ctrl_out,
    output logic        out_valid,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MUL_P,
        S_MUL_I,
        S_MUL_D,
        S_SUM
    } state_t;

    localparam logic signed [17:0] LIM_P = 18'(INT_LIM);
    localparam logic signed [17:0] LIM_N = -LIM_P;

    state_t state;
    state_t state_nxt;

    logic [15:0] sp_q;
    logic [15:0] fs_q;
    logic [15:0] kp_q;
    logic [15:0] ki_q;
    logic [15:0] kd_q;
    logic [15:0] th_q;
    logic        mute_q;

    logic signed [16:0] err_q;
    logic signed [16:0] integ_q;
    logic signed [16:0] prev_q;
    logic signed [35:0] acc_q;

    logic signed [16:0] err_raw;
    logic signed [16:0] err_abs;
    logic signed [16:0] err_db;
    logic signed [17:0] integ_sum;
    logic signed [16:0] integ_nxt;
    logic signed [17:0] d_diff;

    logic signed [17:0] mul_a;
    logic signed [16:0] mul_b;
    logic signed [34:0] prod;
    logic signed [35:0] prod_ext;
    logic signed [35:0] term;
    logic        [15:0] sat_val;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: fixed walk through the six phases
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (sample_tick) state_nxt = S_ERR;
            S_ERR:   state_nxt = S_MUL_P;
            S_MUL_P: state_nxt = S_MUL_I;
            S_MUL_I: state_nxt = S_MUL_D;
            S_MUL_D: state_nxt = S_SUM;
            S_SUM:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and multiplier operand steering
    always_comb begin
        busy  = (state != S_IDLE);
        mul_a = '0;
        mul_b = '0;
        unique case (state)
            S_MUL_P: begin
                mul_a = {err_q[16], err_q};
                mul_b = {1'b0, kp_q};
            end
            S_MUL_I: begin
                mul_a = {integ_q[16], integ_q};
                mul_b = {1'b0, ki_q};
            end
            S_MUL_D: begin
                mul_a = d_diff;
                mul_b = {1'b0, kd_q};
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    // Error with deadband, clamped integrator candidate, derivative delta
    always_comb begin
        err_raw   = $signed({1'b0, sp_q}) - $signed({1'b0, fs_q});
        err_abs   = err_raw[16] ? -err_raw : err_raw;
        err_db    = ($unsigned(err_abs) <= {1'b0, th_q}) ? '0 : err_raw;
        integ_sum = {integ_q[16], integ_q} + {err_db[16], err_db};
        if (integ_sum > LIM_P) begin
            integ_nxt = LIM_P[16:0];
        end else if (integ_sum < LIM_N) begin
            integ_nxt = LIM_N[16:0];
        end else begin
            integ_nxt = integ_sum[16:0];
        end
        d_diff = {err_q[16], err_q} - {prev_q[16], prev_q};
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {prod[34], prod};
    assign term     = prod_ext >>> FRAC_BITS;

    // Clip the wide accumulator into the signed 16-bit output range
    always_comb begin
        if (acc_q > 36'sd32767) begin
            sat_val = 16'h7FFF;
        end else if (acc_q < -36'sd32768) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = acc_q[15:0];
        end
    end

    // Datapath: snapshot, loop state, accumulation, output and overruns
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sp_q        <= '0;
            fs_q        <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            th_q        <= '0;
            mute_q      <= 1'b0;
            err_q       <= '0;
            integ_q     <= '0;
            prev_q      <= '0;
            acc_q       <= '0;
            ctrl_out    <= '0;
            out_valid   <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            if (sample_tick && state != S_IDLE && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            unique case (state)
                S_IDLE: begin
                    if (sample_tick) begin
                        sp_q   <= setpoint;
                        fs_q   <= focus_signal;
                        kp_q   <= kp;
                        ki_q   <= ki;
                        kd_q   <= kd;
                        th_q   <= threshold;
                        mute_q <= mute;
                    end
                end
                S_ERR: begin
                    if (mute_q) begin
                        err_q   <= '0;
                        integ_q <= '0;
                        prev_q  <= '0;
                    end else begin
                        err_q   <= err_db;
                        integ_q <= integ_nxt;
                    end
                end
                S_MUL_P: acc_q <= term;
                S_MUL_I: acc_q <= acc_q + term;
                S_MUL_D: acc_q <= acc_q + term;
                S_SUM: begin
                    ctrl_out  <= mute_q ? 16'h0000 : sat_val;
                    out_valid <= 1'b1;
                    prev_q    <= err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// tb_pid_loop_sequencer: directed PID scenarios checked every cycle
// against a transaction-level model, plus literal expected values.
module tb_pid_loop_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic [15:0] setpoint = '0;
    logic [15:0] focus_signal = '0;
    logic [15:0] kp = '0;
    logic [15:0] ki = '0;
    logic [15:0] kd = '0;
    logic [15:0] threshold = '0;
    logic        mute = 1'b0;
    logic [15:0] ctrl_out;
    logic        out_valid;
    logic        busy;
    logic [7:0]  overrun_cnt;

    always #5 clk = ~clk;

    pid_loop_sequencer dut (
        .clk(clk),
        .reset_n(reset_n),
        .sample_tick(sample_tick),
        .setpoint(setpoint),
        .focus_signal(focus_signal),
        .kp(kp),
        .ki(ki),
        .kd(kd),
        .threshold(threshold),
        .mute(mute),
        .ctrl_out(ctrl_out),
        .out_valid(out_valid),
        .busy(busy),
        .overrun_cnt(overrun_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model state
    int m_cnt = 0;
    int m_integ = 0;
    int m_prev = 0;
    int m_ctrl = 0;
    int m_pend = 0;
    int m_valid = 0;
    int m_ovr = 0;

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // One PID update computed from the values presented with the tick
    task automatic model_accept();
        int e;
        longint p;
        longint i;
        longint d;
        e = int'(setpoint) - int'(focus_signal);
        if ((e < 0 ? -e : e) <= int'(threshold)) e = 0;
        if (mute) begin
            m_integ = 0;
            m_prev  = 0;
            m_pend  = 0;
        end else begin
            m_integ = m_integ + e;
            if (m_integ > 32767) m_integ = 32767;
            if (m_integ < -32767) m_integ = -32767;
            p = (longint'(e) * longint'(kp)) >>> 8;
            i = (longint'(m_integ) * longint'(ki)) >>> 8;
            d = (longint'(e - m_prev) * longint'(kd)) >>> 8;
            m_pend = sat16(p + i + d);
            m_prev = e;
        end
    endtask

    // Model: an accepted tick produces its result five edges later
    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_cnt = 0;
                m_integ = 0;
                m_prev = 0;
                m_ctrl = 0;
                m_pend = 0;
                m_valid = 0;
                m_ovr = 0;
            end else begin
                m_valid = 0;
                if (m_cnt > 0) begin
                    if (sample_tick && m_ovr < 255) m_ovr++;
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_ctrl = m_pend;
                        m_valid = 1;
                    end
                end else if (sample_tick) begin
                    model_accept();
                    m_cnt = 5;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_out_valid", 32'(out_valid), m_valid);
                check("cyc_busy", 32'(busy), (m_cnt > 0) ? 1 : 0);
                check("cyc_ctrl_out", $signed(ctrl_out), m_ctrl);
                check("cyc_overrun", 32'(overrun_cnt), m_ovr);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sample_tick = 1'b0;
        mute = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run(input int sp, input int fs, input int exp, input string name);
        int waits;
        @(negedge clk);
        setpoint = 16'(sp);
        focus_signal = 16'(fs);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check({name, "_busy"}, 32'(busy), 1);
        setpoint = ~setpoint;
        focus_signal = focus_signal ^ 16'h5A5A;
        waits = 0;
        while (out_valid !== 1'b1 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        check({name, "_lat"}, waits, 5);
        check(name, $signed(ctrl_out), exp);
    endtask

    initial begin
        int nv;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset_n = 1'b1;
        check("rst_ctrl", $signed(ctrl_out), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovr", 32'(overrun_cnt), 0);

        kp = 16'h0100; ki = 0; kd = 0; threshold = 0;
        run(512, 500, 12, "p_basic");
        threshold = 20;
        run(512, 500, 0, "dead_in");
        threshold = 12;
        run(512, 500, 0, "dead_edge");
        threshold = 11;
        run(512, 500, 12, "dead_out");

        do_reset();
        kp = 0; ki = 16'h0100; kd = 0; threshold = 0;
        run(512, 500, 12, "int_1");
        run(512, 500, 24, "int_2");
        run(512, 500, 36, "int_3");
        mute = 1'b1;
        run(512, 500, 0, "int_mute");
        mute = 1'b0;
        run(512, 500, 12, "int_unmute");

        do_reset();
        kp = 16'h7FFF; ki = 0; kd = 0;
        run(1000, 0, 32767, "sat_pos");
        run(0, 1000, -32768, "sat_neg");

        do_reset();
        kp = 0; ki = 0; kd = 16'h0100;
        run(512, 500, 12, "d_first");
        run(512, 510, -10, "d_second");

        do_reset();
        kp = 16'h0100; kd = 0;
        setpoint = 16'd512; focus_signal = 16'd500;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid === 1'b1) nv++;
        end
        check("ovr_valid_count", nv, 1);
        check("ovr_cnt2", 32'(overrun_cnt), 2);

        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        check("abort_ctrl", $signed(ctrl_out), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(out_valid), 0);
        check("abort_ovr", 32'(overrun_cnt), 0);
        reset_n = 1'b1;
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) nv++;
        end
        check("abort_no_valid", nv, 0);

        @(negedge clk); sample_tick = 1'b1;
        repeat (400) @(negedge clk);
        sample_tick = 1'b0;
        repeat (8) @(negedge clk);
        check("ovr_sat", 32'(overrun_cnt), 255);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
